// File: rtl/csr_hpm_counters.sv
// ---------------------------------------------------------------------------
// csr_hpm_counters
//
// Machine-mode counter CSRs: mcycle, minstret, NUM_HPM programmable
// performance counters (mhpmcounter3..) with their event selectors
// (mhpmevent3..), and mcountinhibit. Sits beside the machine CSR block.
// The read address comes from decode, the write port from execute and the
// event strobes from the pipeline.
//
// Optional feature, selected with the macro CSR_HPM_OVF_IRQ_EN:
//   defined   - each mhpmcounter has a sticky overflow (OF) bit in
//               mhpmevent[31], and ovf_irq is the registered OR of all OF bits.
//   undefined - no OF logic is built; mhpmevent[31] reads 0 and ignores
//               writes; ovf_irq is tied 0. Counters still wrap silently.
//
// Parameters:
//   NUM_HPM    - implemented mhpmcounter/mhpmevent pairs (0..29)
//   CNT_WIDTH  - implemented width of each mhpmcounter (33..64)
//   NUM_EVENTS - width of the event strobe bus (1..31)
//
// Ports:
//   clock   - system clock
//   reset   - asynchronous active-low reset
//   crden   - read enable
//   craddr  - read CSR address
//   cdata   - read data, combinational from current register state
//   chit    - craddr is a CSR owned by this block and crden=1
//   cwren   - write enable
//   cwaddr  - write CSR address
//   cwdata  - write data, already resolved for csrrs/csrrc
//   retire  - one instruction retired this cycle
//   events  - per-cycle event strobes
//   ovf_irq - registered counter-overflow interrupt request (mip bit 13)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module csr_hpm_counters #(
   parameter int NUM_HPM    = 4,
   parameter int CNT_WIDTH  = 48,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  crden,
   input  logic [11:0]           craddr,
   output logic [31:0]           cdata,
   output logic                  chit,
   input  logic                  cwren,
   input  logic [11:0]           cwaddr,
   input  logic [31:0]           cwdata,
   input  logic                  retire,
   input  logic [NUM_EVENTS-1:0] events,
   output logic                  ovf_irq
);

   // Arrays keep at least one entry so NUM_HPM=0 still elaborates.
   localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
   // Width of the implemented upper half of an mhpmcounter.
   localparam int HW = CNT_WIDTH - 32;

   // Address blocks of 32 CSRs, selected by address bits [11:5].
   localparam logic [6:0] BLK_CNT_LO = 7'h58;   // 0xB00..0xB1F
   localparam logic [6:0] BLK_CNT_HI = 7'h5C;   // 0xB80..0xB9F
   localparam logic [6:0] BLK_EVT    = 7'h19;   // 0x320..0x33F

   localparam logic [4:0] IDX_CYCLE   = 5'd0;
   localparam logic [4:0] IDX_INSTRET = 5'd2;
   localparam logic [4:0] IDX_HPM0    = 5'd3;

   // ------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------
   logic       wr_cnt_lo;
   logic       wr_cnt_hi;
   logic       wr_evt;
   logic [4:0] widx;

   assign widx      = cwaddr[4:0];
   assign wr_cnt_lo = cwren && (cwaddr[11:5] == BLK_CNT_LO);
   assign wr_cnt_hi = cwren && (cwaddr[11:5] == BLK_CNT_HI);
   assign wr_evt    = cwren && (cwaddr[11:5] == BLK_EVT);

   // mhpmevent and mcountinhibit share a block; index 0 is mcountinhibit.
   logic wr_inhibit;
   assign wr_inhibit = wr_evt && (widx == 5'd0);

   // ------------------------------------------------------------------
   // mcountinhibit: CY and IR bits (HPM bits live with each counter)
   // ------------------------------------------------------------------
   logic inh_cy_q;
   logic inh_ir_q;

   // NOTE: state is written with non-blocking assignments so every register
   // in the block samples the same pre-edge values, whatever the block order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inh_cy_q <= 1'b0;
         inh_ir_q <= 1'b0;
      end else if (wr_inhibit) begin
         inh_cy_q <= cwdata[0];
         inh_ir_q <= cwdata[2];
      end
   end

   // ------------------------------------------------------------------
   // mcycle / minstret: 64 bits, no overflow flag. A write to either half
   // wins over the increment and leaves the other half untouched.
   // ------------------------------------------------------------------
   logic [63:0] mcycle_q;
   logic [63:0] minstret_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcycle_q <= '0;
      end else if (wr_cnt_lo && (widx == IDX_CYCLE)) begin
         mcycle_q[31:0] <= cwdata;
      end else if (wr_cnt_hi && (widx == IDX_CYCLE)) begin
         mcycle_q[63:32] <= cwdata;
      end else if (!inh_cy_q) begin
         mcycle_q <= mcycle_q + 64'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         minstret_q <= '0;
      end else if (wr_cnt_lo && (widx == IDX_INSTRET)) begin
         minstret_q[31:0] <= cwdata;
      end else if (wr_cnt_hi && (widx == IDX_INSTRET)) begin
         minstret_q[63:32] <= cwdata;
      end else if (retire && !inh_ir_q) begin
         minstret_q <= minstret_q + 64'd1;
      end
   end

   // ------------------------------------------------------------------
   // Programmable counters
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0]  hpm_cnt  [NH];
   logic [NUM_EVENTS-1:0] hpm_mask [NH];
   logic                  hpm_inh  [NH];
`ifdef CSR_HPM_OVF_IRQ_EN
   logic                  hpm_of   [NH];
`endif

   for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
      localparam logic [4:0] IDX = 5'(k + 3);

      logic [CNT_WIDTH-1:0]  cnt_q;
      logic [NUM_EVENTS-1:0] mask_q;
      logic                  inh_q;
      logic                  sel_lo;
      logic                  sel_hi;
      logic                  sel_evt;
      logic                  inc;

      assign sel_lo  = wr_cnt_lo && (widx == IDX);
      assign sel_hi  = wr_cnt_hi && (widx == IDX);
      assign sel_evt = wr_evt && (widx == IDX);
      // Any selected event counts as exactly one; a zero mask never counts.
      assign inc     = (|(events & mask_q)) && !inh_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
         end else if (sel_lo) begin
            cnt_q[31:0] <= cwdata;
         end else if (sel_hi) begin
            cnt_q[CNT_WIDTH-1:32] <= cwdata[HW-1:0];
         end else if (inc) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            mask_q <= '0;
            inh_q  <= 1'b0;
         end else begin
            if (sel_evt) begin
               mask_q <= cwdata[NUM_EVENTS-1:0];
            end
            if (wr_inhibit) begin
               inh_q <= cwdata[3 + k];
            end
         end
      end

`ifdef CSR_HPM_OVF_IRQ_EN
      logic of_q;
      logic wrap;

      // A counter write suppresses the increment, so it also suppresses wrap.
      assign wrap = inc && !sel_lo && !sel_hi && (cnt_q == '1);

      // Sticky; only an mhpmevent write changes it, and that write beats a
      // simultaneous wrap.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            of_q <= 1'b0;
         end else if (sel_evt) begin
            of_q <= cwdata[31];
         end else if (wrap) begin
            of_q <= 1'b1;
         end
      end

      assign hpm_of[k] = of_q;
`endif

      assign hpm_cnt[k]  = cnt_q;
      assign hpm_mask[k] = mask_q;
      assign hpm_inh[k]  = inh_q;
   end : g_hpm

   if (NUM_HPM == 0) begin : g_no_hpm
      assign hpm_cnt[0]  = '0;
      assign hpm_mask[0] = '0;
      assign hpm_inh[0]  = 1'b0;
`ifdef CSR_HPM_OVF_IRQ_EN
      assign hpm_of[0]   = 1'b0;
`endif
   end : g_no_hpm

   // ------------------------------------------------------------------
   // Overflow interrupt: registered OR of all OF bits
   // ------------------------------------------------------------------
`ifdef CSR_HPM_OVF_IRQ_EN
   logic of_any;
   logic ovf_irq_q;

   always_comb begin
      of_any = 1'b0;
      for (int k = 0; k < NUM_HPM; k++) begin
         of_any = of_any | hpm_of[k];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_irq_q <= 1'b0;
      end else begin
         ovf_irq_q <= of_any;
      end
   end

   assign ovf_irq = ovf_irq_q;
`else
   assign ovf_irq = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read mux. Indices 3..31 in the counter/event blocks are always owned;
   // those beyond NUM_HPM simply read 0.
   // ------------------------------------------------------------------
   logic [4:0]  ridx;
   logic [63:0] cnt_sel;
   logic [31:0] evt_sel;
   logic [31:0] inh_rd;

   assign ridx = craddr[4:0];

   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      cnt_sel = '0;
      evt_sel = '0;
      inh_rd  = '0;
      inh_rd[0] = inh_cy_q;
      inh_rd[2] = inh_ir_q;
      for (int k = 0; k < NUM_HPM; k++) begin
         inh_rd[3 + k] = hpm_inh[k];
         if (ridx == 5'(k + 3)) begin
            cnt_sel = 64'(hpm_cnt[k]);
            evt_sel[NUM_EVENTS-1:0] = hpm_mask[k];
`ifdef CSR_HPM_OVF_IRQ_EN
            evt_sel[31] = hpm_of[k];
`endif
         end
      end
   end

   always_comb begin
      cdata = '0;
      chit  = 1'b0;
      if (crden) begin
         case (craddr[11:5])
            BLK_CNT_LO: begin
               if (ridx == IDX_CYCLE) begin
                  chit  = 1'b1;
                  cdata = mcycle_q[31:0];
               end else if (ridx == IDX_INSTRET) begin
                  chit  = 1'b1;
                  cdata = minstret_q[31:0];
               end else if (ridx >= IDX_HPM0) begin
                  chit  = 1'b1;
                  cdata = cnt_sel[31:0];
               end
            end
            BLK_CNT_HI: begin
               if (ridx == IDX_CYCLE) begin
                  chit  = 1'b1;
                  cdata = mcycle_q[63:32];
               end else if (ridx == IDX_INSTRET) begin
                  chit  = 1'b1;
                  cdata = minstret_q[63:32];
               end else if (ridx >= IDX_HPM0) begin
                  chit  = 1'b1;
                  cdata = cnt_sel[63:32];
               end
            end
            BLK_EVT: begin
               if (ridx == 5'd0) begin
                  chit  = 1'b1;
                  cdata = inh_rd;
               end else if (ridx >= IDX_HPM0) begin
                  chit  = 1'b1;
                  cdata = evt_sel;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : csr_hpm_counters
